// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat datapath: card-source states and load-strobe indices.
package baccarat_pkg;
  localparam int CARDS_PER_DECK = 52;

  typedef enum logic {RUN = 1'b0, SHUFFLE = 1'b1} state_e;

  localparam int PCARD1 = 0;
  localparam int PCARD2 = 1;
  localparam int PCARD3 = 2;
  localparam int DCARD1 = 3;
  localparam int DCARD2 = 4;
  localparam int DCARD3 = 5;
endpackage

// File: rtl/shoe_scheduler_sat_counter.sv
// Saturating up-counter with synchronous active-low reset, used for the session tally.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         slow_clock,
  input  logic         resetb,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/shoe_scheduler.sv
// Shares the deck generator among the six card registers, tracks the shoe and inserts shuffles.
// Build option: define BACCARAT_TALLY_EN to compile in the player/dealer/tie session tally.
module shoe_scheduler
  import baccarat_pkg::*;
#(
  parameter int DECKS     = 8,
  parameter int CUT_CARDS = 16,
  parameter int SHUF_LEN  = 4,
  parameter int TALLY_W   = 8,
  localparam int CL_W     = $clog2(DECKS*CARDS_PER_DECK+1)
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic [5:0]         req,
  input  logic [3:0]         new_card,
  input  logic               player_win_light,
  input  logic               dealer_win_light,
  input  logic               shuffle_req,
  output logic [5:0]         card_we,
  output logic [3:0]         card_out,
  output logic               deal_resetb,
  output logic               shuffling,
  output logic [CL_W-1:0]    cards_left,
  output logic               shoe_err,
  output logic [TALLY_W-1:0] player_wins,
  output logic [TALLY_W-1:0] dealer_wins,
  output logic [TALLY_W-1:0] ties
);
  localparam logic [CL_W-1:0] FULL_SHOE = CL_W'(DECKS*CARDS_PER_DECK);
  localparam int SHUF_W = (SHUF_LEN > 1) ? $clog2(SHUF_LEN) : 1;

  state_e            state_q, state_d;
  logic [SHUF_W-1:0] cnt_q, cnt_d;
  logic [CL_W-1:0]   left_q, left_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;
  logic              lights_q;

  logic       lights_or, round_end, multi, grant_any;
  logic [5:0] lowest;

  // Zero-latency grant: isolate the lowest set strobe and pass the card straight through.
  assign lowest    = req & (~req + 6'd1);
  assign multi     = |(req & (req - 6'd1));
  assign card_we   = (state_q == RUN) ? lowest : 6'd0;
  assign card_out  = new_card;
  assign grant_any = |card_we;

  assign lights_or = player_win_light | dealer_win_light;
  assign round_end = lights_or & ~lights_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    err_d   = err_q;
    pend_d  = pend_q;
    if (grant_any) begin
      if (left_q == '0) err_d = 1'b1;
      else              left_d = left_q - CL_W'(1);
    end
    if (multi && (state_q == RUN)) err_d = 1'b1;
    case (state_q)
      RUN: begin
        if (shuffle_req) pend_d = 1'b1;
        // A request arriving with the round end still counts for this round.
        if (round_end && ((left_q <= CL_W'(CUT_CARDS)) || pend_q || shuffle_req)) begin
          state_d = SHUFFLE;
          cnt_d   = SHUF_W'(SHUF_LEN - 1);
          pend_d  = 1'b0;
        end
      end
      SHUFFLE: begin
        if (cnt_q == '0) begin
          state_d = RUN;
          left_d  = FULL_SHOE;
        end else begin
          cnt_d = cnt_q - SHUF_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      left_q   <= FULL_SHOE;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      lights_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      lights_q <= lights_or;
    end
  end

  assign shuffling   = (state_q == SHUFFLE);
  assign deal_resetb = resetb & ~shuffling;
  assign cards_left  = left_q;
  assign shoe_err    = err_q;

`ifdef BACCARAT_TALLY_EN
  sat_counter #(.W(TALLY_W)) u_player (
    .slow_clock(slow_clock), .resetb(resetb),
    .inc(round_end & player_win_light & ~dealer_win_light), .count(player_wins));
  sat_counter #(.W(TALLY_W)) u_dealer (
    .slow_clock(slow_clock), .resetb(resetb),
    .inc(round_end & dealer_win_light & ~player_win_light), .count(dealer_wins));
  sat_counter #(.W(TALLY_W)) u_ties (
    .slow_clock(slow_clock), .resetb(resetb),
    .inc(round_end & player_win_light & dealer_win_light), .count(ties));
`else
  assign player_wins = '0;
  assign dealer_wins = '0;
  assign ties        = '0;
`endif
endmodule

// File: tb/tb_shoe_scheduler.sv
// Directed bench for shoe_scheduler: grant path, shoe count, shuffle interval, reset, tally.
module tb_shoe_scheduler;
  localparam int CL_W = $clog2(8*52+1);
`ifdef BACCARAT_TALLY_EN
  localparam bit TALLY = 1'b1;
`else
  localparam bit TALLY = 1'b0;
`endif

  logic            slow_clock = 1'b0;
  logic            resetb = 1'b0;
  logic [5:0]      req = '0;
  logic [3:0]      new_card = '0;
  logic            pwl = 1'b0, dwl = 1'b0, shuffle_req = 1'b0;
  logic [5:0]      card_we;
  logic [3:0]      card_out;
  logic            deal_resetb, shuffling, shoe_err;
  logic [CL_W-1:0] cards_left;
  logic [1:0]      player_wins, dealer_wins, ties;

  int n_tests = 0;
  int n_fail  = 0;

  shoe_scheduler #(.DECKS(8), .CUT_CARDS(16), .SHUF_LEN(4), .TALLY_W(2)) dut (
    .slow_clock(slow_clock), .resetb(resetb), .req(req), .new_card(new_card),
    .player_win_light(pwl), .dealer_win_light(dwl), .shuffle_req(shuffle_req),
    .card_we(card_we), .card_out(card_out), .deal_resetb(deal_resetb),
    .shuffling(shuffling), .cards_left(cards_left), .shoe_err(shoe_err),
    .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties));

  always #5 slow_clock = ~slow_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clock); #1;
  endtask

  task automatic round(input logic p, input logic d, input int hold);
    pwl = p; dwl = d;
    repeat (hold) tick();
    pwl = 1'b0; dwl = 1'b0;
    tick();
  endtask

  logic [5:0] deal_req  [4] = '{6'h01, 6'h08, 6'h02, 6'h10};
  logic [3:0] deal_card [4] = '{4'd3, 4'd5, 4'd9, 4'd1};

  initial begin
    // reset state
    tick(); tick();
    @(negedge slow_clock);
    chk("rst_deal_resetb", 32'(deal_resetb), 0);
    chk("rst_cards_left", 32'(cards_left), 416);
    chk("rst_shuffling", 32'(shuffling), 0);
    chk("rst_err", 32'(shoe_err), 0);
    chk("rst_tally", 32'({player_wins, dealer_wins, ties}), 0);
    chk("rst_card_we", 32'(card_we), 0);
    tick();
    resetb = 1'b1;
    @(negedge slow_clock);
    chk("run_deal_resetb", 32'(deal_resetb), 1);
    tick();

    // four-card deal
    for (int i = 0; i < 4; i++) begin
      req = deal_req[i]; new_card = deal_card[i];
      @(negedge slow_clock);
      chk($sformatf("deal_we%0d", i), 32'(card_we), 32'(deal_req[i]));
      chk($sformatf("deal_card%0d", i), 32'(card_out), 32'(deal_card[i]));
      tick();
    end
    req = '0;
    chk("deal_left", 32'(cards_left), 412);
    chk("deal_err", 32'(shoe_err), 0);

    // operator shuffle waits for round end
    shuffle_req = 1'b1; tick(); shuffle_req = 1'b0;
    repeat (3) tick();
    chk("pend_no_early", 32'(shuffling), 0);
    pwl = 1'b1; tick(); pwl = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge slow_clock);
      chk($sformatf("pend_shuf%0d", k), 32'(shuffling), 1);
      chk($sformatf("pend_dres%0d", k), 32'(deal_resetb), 0);
      tick();
    end
    chk("pend_done", 32'(shuffling), 0);
    chk("pend_dres_back", 32'(deal_resetb), 1);
    chk("pend_full", 32'(cards_left), 416);
    chk("pw_1", 32'(player_wins), TALLY ? 1 : 0);

    // tally with saturation and a held light
    round(1'b1, 1'b0, 1);
    chk("pw_2", 32'(player_wins), TALLY ? 2 : 0);
    round(1'b1, 1'b0, 5);
    chk("pw_held", 32'(player_wins), TALLY ? 3 : 0);
    round(1'b1, 1'b0, 1);
    round(1'b1, 1'b0, 1);
    round(1'b1, 1'b1, 1);
    chk("pw_sat", 32'(player_wins), TALLY ? 3 : 0);
    chk("ties_1", 32'(ties), TALLY ? 1 : 0);
    chk("dw_0", 32'(dealer_wins), 0);
    chk("no_shuf_rounds", 32'(shuffling), 0);

    // two strobes at once
    req = 6'b000101;
    @(negedge slow_clock);
    chk("multi_we", 32'(card_we), 32'h01);
    tick(); req = '0;
    chk("multi_err", 32'(shoe_err), 1);
    chk("multi_left", 32'(cards_left), 415);
    repeat (3) tick();
    chk("err_sticky", 32'(shoe_err), 1);

    resetb = 1'b0; tick();
    chk("rst2_err", 32'(shoe_err), 0);
    chk("rst2_tally", 32'({player_wins, ties}), 0);
    chk("rst2_left", 32'(cards_left), 416);
    resetb = 1'b1; tick();

    // deal down to the cut card
    req = 6'b100000;
    repeat (400) tick();
    req = '0;
    chk("cut_left", 32'(cards_left), 16);
    dwl = 1'b1; tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge slow_clock);
      chk($sformatf("cut_shuf%0d", k), 32'(shuffling), 1);
      chk($sformatf("cut_dres%0d", k), 32'(deal_resetb), 0);
      shuffle_req = (k == 0);
      tick();
      shuffle_req = 1'b0;
      if (k == 1) dwl = 1'b0;
    end
    chk("cut_done", 32'(shuffling), 0);
    chk("cut_full", 32'(cards_left), 416);
    chk("dw_held", 32'(dealer_wins), TALLY ? 1 : 0);
    round(1'b1, 1'b0, 1);
    chk("req_in_shuf_ignored", 32'(shuffling), 0);

    // reset during the second shuffle cycle
    req = 6'b000001;
    repeat (3) tick();
    req = '0;
    chk("pre_rst_left", 32'(cards_left), 413);
    shuffle_req = 1'b1; pwl = 1'b1; tick();
    shuffle_req = 1'b0; pwl = 1'b0;
    chk("same_cycle_shuf", 32'(shuffling), 1);
    tick();
    chk("shuf_cycle2", 32'(shuffling), 1);
    resetb = 1'b0; tick();
    chk("midrst_shuf", 32'(shuffling), 0);
    chk("midrst_full", 32'(cards_left), 416);
    chk("midrst_tally", 32'({player_wins, dealer_wins}), 0);
    resetb = 1'b1; tick();

    // empty shoe: card still passes, count pinned at zero
    req = 6'b000001;
    repeat (416) tick();
    chk("empty_left", 32'(cards_left), 0);
    chk("empty_err0", 32'(shoe_err), 0);
    req = 6'b000010; new_card = 4'd7;
    @(negedge slow_clock);
    chk("under_we", 32'(card_we), 32'h02);
    chk("under_card", 32'(card_out), 7);
    tick(); req = '0;
    chk("under_left", 32'(cards_left), 0);
    chk("under_err", 32'(shoe_err), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
